mux16_rr_scheduler: RTL and testbench

Round-robin arbiter that shares one 16:1 bit-select mux among 16 requesters. It picks one requester, drives the 4-bit select, and streams that requester's data bit downstream through a valid/ready handshake for a bounded burst. The 16:1 mux is instantiated internally, so the block is a drop-in front end for any consumer of a shared 16-source bit lane.

---
 rtl/mux16_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_mux16_rr_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler that owns a shared 16:1 bit lane and streams the winner's bit in bounded bursts.
// Grant is registered one edge after the request; outd/out_valid are combinational and hold while out_ready is low.

module mux16_bit (
    input  logic [15:0] d_i,
    input  logic [3:0]  sel_i,
    output logic        y_o
);
    assign y_o = d_i[sel_i];
endmodule

module mux16_rr_scheduler #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    input  logic [15:0] datain,
    input  logic        out_ready,
    output logic [3:0]  select,
    output logic [15:0] grant,
    output logic        outd,
    output logic        out_valid,
    output logic        last
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;
    localparam logic [3:0] LAST_BEAT = 4'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("HOLD_CYCLES must be within 1..15");
    end

    logic [0:0]  state_q, state_d;
    logic [3:0]  select_q, select_d;
    logic [15:0] grant_q, grant_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;

    logic [3:0]  arb_base;
    logic [3:0]  winner;
    logic        found;
    logic        can_grant;
    logic        accept;
    logic        rel;
    logic        mux_y;

    // On release the outgoing owner is the search base, so it ranks last.
    always_comb begin
        logic [3:0] idx;
        arb_base = (state_q == S_XFER) ? select_q : ptr_q;
        winner   = 4'd0;
        found    = 1'b0;
        idx      = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            idx = arb_base + 4'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign can_grant = en && found;
    assign out_valid = (state_q == S_XFER) && req[select_q];
    assign accept    = out_valid && out_ready;
    assign rel       = (state_q == S_XFER) &&
                       ((accept && beat_cnt_q == LAST_BEAT) || !req[select_q]);

    always_comb begin
        state_d    = state_q;
        select_d   = select_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    state_d    = S_XFER;
                    select_d   = winner;
                    grant_d    = 16'd1 << winner;
                    beat_cnt_d = 4'd0;
                end
            end
            default: begin
                if (rel) begin
                    ptr_d = select_q;
                    if (can_grant) begin
                        select_d   = winner;
                        grant_d    = 16'd1 << winner;
                        beat_cnt_d = 4'd0;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = 16'd0;
                    end
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            select_q   <= 4'd0;
            grant_q    <= 16'd0;
            ptr_q      <= 4'd15;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    mux16_bit u_mux (
        .d_i   (datain),
        .sel_i (select_q),
        .y_o   (mux_y)
    );

    assign select = select_q;
    assign grant  = grant_q;
    assign outd   = out_valid & mux_y;
    assign last   = out_valid && (beat_cnt_q == LAST_BEAT);

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed bench for mux16_rr_scheduler with HOLD_CYCLES=4.

module tb_mux16_rr_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic [15:0] datain;
    logic        out_ready;
    logic [3:0]  select;
    logic [15:0] grant;
    logic        outd;
    logic        out_valid;
    logic        last;

    int n_tests = 0;
    int n_fail  = 0;

    mux16_rr_scheduler #(.HOLD_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .datain    (datain),
        .out_ready (out_ready),
        .select    (select),
        .grant     (grant),
        .outd      (outd),
        .out_valid (out_valid),
        .last      (last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Counts accepted beats until the grant drops, bounded so a stuck grant fails instead of hanging.
    task automatic count_beats(output int beats);
        int guard;
        beats = 0;
        guard = 0;
        while (grant != 16'd0 && guard < 20) begin
            if (out_valid && out_ready) beats++;
            tick();
            guard++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int s;
        rst_n = 1'b0; en = 1'b0; req = 16'h0; datain = 16'h0; out_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_outd", 32'(outd), 32'd0);
        #9;
        rst_n = 1'b1; en = 1'b1; req = 16'h0001; datain = 16'h0001; out_ready = 1'b1;

        // Single requester: one burst then back to IDLE once en drops.
        tick();
        chk("t1_grant", 32'(grant), 32'h0001);
        chk("t1_select", 32'(select), 32'd0);
        chk("t1_outd", 32'(outd), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_last", 32'(last), (i == 3) ? 32'd1 : 32'd0);
            chk("t1_valid", 32'(out_valid), 32'd1);
            tick();
        end
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_idle_valid", 32'(out_valid), 32'd0);
        chk("t1_idle_select", 32'(select), 32'd0);

        // All requesting: strict rotation, 4 beats each, no bubbles.
        do_reset();
        req = 16'hFFFF; en = 1'b1; datain = 16'hA5C3;
        tick();
        for (int g = 0; g < 17; g++) begin
            s = g % 16;
            for (int c = 0; c < 4; c++) begin
                chk("t2_select", 32'(select), 32'(s));
                chk("t2_grant", 32'(grant), 32'(16'd1 << s));
                chk("t2_outd", 32'(outd), 32'(datain[s]));
                tick();
            end
        end
        chk("t2_next", 32'(select), 32'd1);

        // Wrap priority: 14 withdraws, then 15 -> 0 -> 2.
        do_reset();
        req = 16'h4000; en = 1'b1;
        tick();
        chk("t3_first", 32'(select), 32'd14);
        req = 16'h8005;
        tick();
        chk("t3_sel15", 32'(select), 32'd15);
        chk("t3_grant15", 32'(grant), 32'h8000);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_sel0", 32'(select), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_sel2", 32'(select), 32'd2);
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_idle", 32'(grant), 32'h0);

        // Stall: out_ready low for 10 cycles after the first beat.
        req = 16'h0020; en = 1'b1;
        tick();
        chk("t4_select", 32'(select), 32'd5);
        en = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            datain = datain ^ 16'h0020;
            #1;
            chk("t4_valid", 32'(out_valid), 32'd1);
            chk("t4_outd", 32'(outd), 32'(datain[5]));
            chk("t4_hold", 32'(select), 32'd5);
            tick();
        end
        out_ready = 1'b1;
        count_beats(beats);
        chk("t4_beats", 32'(beats + 1), 32'd4);

        // Withdrawal of 7 after one beat hands over to 9 with a fresh count.
        req = 16'h0280; en = 1'b1;
        tick();
        chk("t5_sel7", 32'(select), 32'd7);
        tick();
        req = 16'h0200;
        #1;
        chk("t5_wd_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t5_sel9", 32'(select), 32'd9);
        chk("t5_grant9", 32'(grant), 32'h0200);
        en = 1'b0;
        count_beats(beats);
        chk("t5_beats", 32'(beats), 32'd4);
        tick();
        tick();
        chk("t5_en0_grant", 32'(grant), 32'h0);
        chk("t5_en0_valid", 32'(out_valid), 32'd0);

        // Async reset mid-burst at select 9, beat 2.
        en = 1'b1;
        tick();
        chk("t6_sel9", 32'(select), 32'd9);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_grant", 32'(grant), 32'h0);
        chk("t6_rst_select", 32'(select), 32'd0);
        #1;
        rst_n = 1'b1;
        req = 16'h0201;
        tick();
        chk("t6_after", 32'(select), 32'd0);
        chk("t6_after_grant", 32'(grant), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
